// File: rtl/peridot_byte2packet.sv
// Byte-stream to packet decoder: strips SOP/EOP/channel marks and escapes,
// presenting payload bytes with packet flags through a single output register.
module peridot_byte2packet #(
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                     clock_sig,
  input  logic                     reset_sig,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [CHANNEL_WIDTH-1:0] out_channel
);

  // state       | meaning
  // DATA        | decoding marks and plain payload
  // ESCAPE      | next byte is payload, XOR 0x20
  // CHANNEL     | next byte is the channel number (0x7D escapes it)
  // CHANNEL_ESC | next byte XOR 0x20 is the channel number
  typedef enum logic [1:0] {DATA, ESCAPE, CHANNEL, CHANNEL_ESC} state_t;

  localparam logic [7:0] SOP_MARK = 8'h7A;
  localparam logic [7:0] EOP_MARK = 8'h7B;
  localparam logic [7:0] CH_MARK  = 8'h7C;
  localparam logic [7:0] ESC_MARK = 8'h7D;

  state_t                   state;
  logic                     sop_pending;
  logic                     eop_pending;
  logic [CHANNEL_WIDTH-1:0] channel_reg;
  logic                     accept;
  logic                     emit;
  logic [7:0]               emit_data;
  logic [7:0]               esc_byte;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign esc_byte = in_data ^ 8'h20;

  always_comb begin
    emit      = 1'b0;
    emit_data = in_data;
    case (state)
      DATA:    emit = (in_data < SOP_MARK) || (in_data > ESC_MARK);
      ESCAPE: begin
        emit      = 1'b1;
        emit_data = esc_byte;
      end
      default: emit = 1'b0;
    endcase
  end

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state             <= DATA;
      sop_pending       <= 1'b0;
      eop_pending       <= 1'b0;
      channel_reg       <= '0;
      out_valid         <= 1'b0;
      out_data          <= 8'h00;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_channel       <= '0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (accept) begin
        // a reload in the same cycle as a drain overrides the clear above
        if (emit) begin
          out_valid         <= 1'b1;
          out_data          <= emit_data;
          out_startofpacket <= sop_pending;
          out_endofpacket   <= eop_pending;
          out_channel       <= channel_reg;
          sop_pending       <= 1'b0;
          eop_pending       <= 1'b0;
        end
        case (state)
          DATA: begin
            case (in_data)
              SOP_MARK: sop_pending <= 1'b1;
              EOP_MARK: eop_pending <= 1'b1;
              CH_MARK:  state <= CHANNEL;
              ESC_MARK: state <= ESCAPE;
              default:  state <= DATA;
            endcase
          end
          ESCAPE: state <= DATA;
          CHANNEL: begin
            if (in_data == ESC_MARK) begin
              state <= CHANNEL_ESC;
            end else begin
              channel_reg <= in_data[CHANNEL_WIDTH-1:0];
              state       <= DATA;
            end
          end
          CHANNEL_ESC: begin
            channel_reg <= esc_byte[CHANNEL_WIDTH-1:0];
            state       <= DATA;
          end
          default: state <= DATA;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_peridot_byte2packet.sv
// Bench for peridot_byte2packet: directed vector table, reset corner cases,
// and a random stream scored against a reference decoder.
module tb_peridot_byte2packet;

  logic       clock_sig = 1'b0;
  logic       reset_sig;
  logic       in_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_startofpacket;
  logic       out_endofpacket;
  logic [7:0] out_channel;

  int n_checks = 0;
  int n_fail   = 0;

  peridot_byte2packet #(.CHANNEL_WIDTH(8)) dut (
    .clock_sig(clock_sig), .reset_sig(reset_sig),
    .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
    .out_channel(out_channel)
  );

  always #5 clock_sig = ~clock_sig;

  typedef struct {
    logic       vld;
    logic [7:0] din;
    logic       ordy;
    logic       exp_irdy;
    logic       exp_ov;
    logic [7:0] exp_dat;
    logic       exp_sop;
    logic       exp_eop;
    logic [7:0] exp_ch;
  } vec_t;

  typedef struct {
    logic [7:0] dat;
    logic       sop;
    logic       eop;
    logic [7:0] ch;
  } pkt_t;

  vec_t vecs[$];
  pkt_t expq[$];

  int         m_state;
  logic       m_sop, m_eop;
  logic [7:0] m_ch;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic vld, input logic [7:0] din, input logic ordy,
                     input logic irdy, input logic ov, input logic [7:0] dat,
                     input logic sop, input logic eop, input logic [7:0] ch);
    vec_t v;
    v.vld = vld; v.din = din; v.ordy = ordy; v.exp_irdy = irdy; v.exp_ov = ov;
    v.exp_dat = dat; v.exp_sop = sop; v.exp_eop = eop; v.exp_ch = ch;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    in_valid  = v.vld;
    in_data   = v.din;
    out_ready = v.ordy;
    #1;
    chk($sformatf("vec%0d in_ready", idx), in_ready, v.exp_irdy);
    @(posedge clock_sig); #1;
    chk($sformatf("vec%0d out_valid", idx), out_valid, v.exp_ov);
    if (v.exp_ov) begin
      chk($sformatf("vec%0d out_data", idx), out_data, v.exp_dat);
      chk($sformatf("vec%0d sop", idx), out_startofpacket, v.exp_sop);
      chk($sformatf("vec%0d eop", idx), out_endofpacket, v.exp_eop);
      chk($sformatf("vec%0d channel", idx), out_channel, v.exp_ch);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1; in_data = b; out_ready = 1'b1;
    @(posedge clock_sig); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 reset_sig = 1'b1;
    #1 chk("async reset out_valid", out_valid, 1'b0);
    #1 reset_sig = 1'b0;
  endtask

  // Reference decoder, fed with each accepted byte.
  task automatic ref_decode(input logic [7:0] b);
    pkt_t p;
    case (m_state)
      0: begin
        if (b == 8'h7A) m_sop = 1'b1;
        else if (b == 8'h7B) m_eop = 1'b1;
        else if (b == 8'h7C) m_state = 2;
        else if (b == 8'h7D) m_state = 1;
        else begin
          p.dat = b; p.sop = m_sop; p.eop = m_eop; p.ch = m_ch;
          expq.push_back(p); m_sop = 1'b0; m_eop = 1'b0;
        end
      end
      1: begin
        p.dat = b ^ 8'h20; p.sop = m_sop; p.eop = m_eop; p.ch = m_ch;
        expq.push_back(p); m_sop = 1'b0; m_eop = 1'b0; m_state = 0;
      end
      2: begin
        if (b == 8'h7D) m_state = 3;
        else begin m_ch = b; m_state = 0; end
      end
      default: begin m_ch = b ^ 8'h20; m_state = 0; end
    endcase
  endtask

  task automatic rand_cycle(input logic vld, input logic [7:0] din, input logic ordy);
    logic hs_in, hs_out, pv;
    logic [7:0] pd, pc;
    logic ps, pe;
    pkt_t p;
    in_valid = vld; in_data = din; out_ready = ordy;
    #2;
    chk("rand in_ready", in_ready, !out_valid || ordy);
    hs_in  = in_valid && in_ready;
    hs_out = out_valid && out_ready;
    pv = out_valid; pd = out_data; ps = out_startofpacket; pe = out_endofpacket; pc = out_channel;
    @(posedge clock_sig); #1;
    if (hs_out) begin
      if (expq.size() == 0) begin
        chk("rand unexpected output", 1'b1, 1'b0);
      end else begin
        p = expq.pop_front();
        chk("rand payload", {pd, ps, pe, pc}, {p.dat, p.sop, p.eop, p.ch});
      end
    end else if (pv) begin
      chk("rand held stable", {out_valid, out_data, out_startofpacket, out_endofpacket, out_channel},
          {1'b1, pd, ps, pe, pc});
    end
    if (hs_in) ref_decode(din);
  endtask

  initial begin
    logic [7:0] rb;
    reset_sig = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    #12;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset out_data", out_data, 8'h00);
    chk("reset sop/eop", {out_startofpacket, out_endofpacket}, 2'b00);
    chk("reset channel", out_channel, 8'h00);
    chk("reset in_ready", in_ready, 1'b1);
    @(negedge clock_sig); reset_sig = 1'b0;

    // channel 5, SOP, three payloads with EOP on the last
    add(1, 8'h7C, 1, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h05, 1, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h7A, 1, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h11, 1, 1, 1, 8'h11, 1, 0, 8'h05);
    add(1, 8'h22, 1, 1, 1, 8'h22, 0, 0, 8'h05);
    add(1, 8'h7B, 1, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h33, 1, 1, 1, 8'h33, 0, 1, 8'h05);
    add(0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'h00);
    // SOP+EOP on one escaped byte; channel persists
    add(1, 8'h7A, 1, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h7B, 1, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h7D, 1, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h5A, 1, 1, 1, 8'h7A, 1, 1, 8'h05);
    add(0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'h00);
    // escaped channel number
    add(1, 8'h7C, 1, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h7D, 1, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h5C, 1, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h7A, 1, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h44, 1, 1, 1, 8'h44, 1, 0, 8'h7C);
    add(0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'h00);
    // backpressure: blocked bytes (including a mark) are not consumed
    add(1, 8'h01, 0, 1, 1, 8'h01, 0, 0, 8'h7C);
    add(1, 8'h7A, 0, 0, 1, 8'h01, 0, 0, 8'h7C);
    add(1, 8'h02, 0, 0, 1, 8'h01, 0, 0, 8'h7C);
    add(1, 8'h02, 1, 1, 1, 8'h02, 0, 0, 8'h7C);
    add(1, 8'h03, 1, 1, 1, 8'h03, 0, 0, 8'h7C);
    add(0, 8'h00, 0, 0, 1, 8'h03, 0, 0, 8'h7C);
    add(0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'h00);
    // escape of the escape code itself
    add(1, 8'h7D, 1, 1, 0, 8'h00, 0, 0, 8'h00);
    add(1, 8'h7D, 1, 1, 1, 8'h5D, 0, 0, 8'h7C);
    add(0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'h00);

    @(posedge clock_sig); #1;
    foreach (vecs[i]) run_vec(vecs[i], i);

    // reset mid-escape: next byte decoded plainly, channel back to 0
    send(8'h7D);
    pulse_reset();
    send(8'h41);
    chk("rst-esc out_valid", out_valid, 1'b1);
    chk("rst-esc out_data", out_data, 8'h41);
    chk("rst-esc sop", out_startofpacket, 1'b0);
    chk("rst-esc channel", out_channel, 8'h00);

    // reset mid-channel with SOP pending
    send(8'h7A);
    send(8'h7C);
    pulse_reset();
    send(8'h41);
    chk("rst-ch out_data", out_data, 8'h41);
    chk("rst-ch sop", out_startofpacket, 1'b0);
    chk("rst-ch channel", out_channel, 8'h00);

    // random stream against the reference decoder, starting from reset
    pulse_reset();
    m_state = 0; m_sop = 1'b0; m_eop = 1'b0; m_ch = 8'h00;
    @(posedge clock_sig); #1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) < 4) rb = 8'h7A + 8'($urandom_range(0, 3));
      else rb = 8'($urandom_range(0, 255));
      rand_cycle(1'($urandom_range(0, 1)), rb, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) rand_cycle(1'b0, 8'h00, 1'b1);
    chk("rand all delivered", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/peridot_byte2packet.md
PERIDOT_BYTE2PACKET -- requirements
Module: peridot_byte2packet

Interface
REQ-001 SHALL provide parameter CHANNEL_WIDTH, default 8, meaning width of out_channel (1..8); the received channel byte is truncated to the LSBs.
REQ-002 SHALL provide clock_sig  input  1  clock; all registers on the rising edge.
REQ-003 SHALL provide reset_sig  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide in_ready  output  1  upstream byte accept (toward the configuration-layer stage).
REQ-005 SHALL provide in_valid  input  1  upstream byte valid.
REQ-006 SHALL provide in_data  input  8  upstream byte.
REQ-007 SHALL provide out_ready  input  1  downstream packet sink ready.
REQ-008 SHALL provide out_valid  output  1  output data valid.
REQ-009 SHALL provide out_data  output  8  decoded payload byte.
REQ-010 SHALL provide out_startofpacket  output  1  first byte of packet.
REQ-011 SHALL provide out_endofpacket  output  1  last byte of packet.
REQ-012 SHALL provide out_channel  output  CHANNEL_WIDTH  channel of the current byte.

Function
REQ-013 SHALL decode control bytes 0x7A=SOP mark, 0x7B=EOP mark, 0x7C=channel mark, 0x7D=escape; every other byte is payload.
REQ-014 SHALL use a single-entry output register; in_ready = !out_valid || out_ready, the same for every byte class.
REQ-015 SHALL accept a byte only on in_valid && in_ready; no state changes on any other cycle.
REQ-016 SHALL load the output register one cycle after a payload byte is accepted (latency 1); out_valid stays high until out_valid && out_ready.
REQ-017 SHALL allow back-to-back throughput of 1 byte/cycle while out_ready is held high.
REQ-018 SHALL implement states DATA, ESCAPE, CHANNEL and CHANNEL_ESC; reset state is DATA.
REQ-019 In DATA, on 0x7A: set the sop_pending flag, stay in DATA, emit nothing.
REQ-020 In DATA, on 0x7B: set the eop_pending flag, stay in DATA, emit nothing.
REQ-021 In DATA, on 0x7C: go to CHANNEL, emit nothing.
REQ-022 In DATA, on 0x7D: go to ESCAPE, emit nothing.
REQ-023 In DATA, on any other byte: emit it as payload.
REQ-024 In ESCAPE, any accepted byte SHALL be emitted as payload (byte XOR 0x20) and return to DATA; control codes are not interpreted.
REQ-025 In CHANNEL, 0x7D SHALL go to CHANNEL_ESC; any other byte SHALL load channel_reg with the byte as-is and return to DATA.
REQ-026 In CHANNEL_ESC, the accepted byte XOR 0x20 SHALL load channel_reg, then return to DATA.
REQ-027 On payload emit, the output register SHALL capture out_startofpacket=sop_pending, out_endofpacket=eop_pending and out_channel=channel_reg, then clear both pending flags.
REQ-028 Repeated 0x7A or 0x7B before a payload byte SHALL leave the flag set (idempotent); SOP and EOP both pending SHALL give one byte with both flags.
REQ-029 channel_reg SHALL persist across packets until the next channel mark.
REQ-030 The output register (data, flags, channel) SHALL be stable while out_valid && !out_ready.
REQ-031 When the output register drains and a new payload byte is accepted in the same cycle, the register SHALL reload with no bubble.

Reset
REQ-032 On reset_sig, the block SHALL go to state DATA, clear sop_pending and eop_pending, and set channel_reg=0.
REQ-033 On reset_sig, outputs SHALL be out_valid=0, out_data=0x00, out_startofpacket=0, out_endofpacket=0 and out_channel=0.
REQ-034 After reset, in_ready SHALL be 1.
REQ-035 Reset mid-escape or mid-channel SHALL discard the partial sequence; the next byte is decoded in DATA.

Verification
REQ-036 Stream 7C 05 7A 11 22 7B 33 with out_ready=1 -> 3 outputs: 11(sop,ch5), 22(ch5), 33(eop,ch5).
REQ-037 Stream 7A 7B 7D 5A -> single output 0x7A with sop=1 and eop=1.
REQ-038 Stream 7C 7D 5C 7A 44 -> output 0x44, sop=1, out_channel=0x7C (truncated per CHANNEL_WIDTH).
REQ-039 out_ready=0 with 3 payload bytes offered -> first byte held stable, in_ready=0; release -> bytes delivered in order, no loss or duplication.
REQ-040 Assert reset_sig after 7D -> then send 41 -> output 0x41 unescaped, sop=0, out_channel=0.
REQ-041 Random stream under random out_ready, checked against a reference decoder -> exact payload, flag and channel match.
